// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream for fifo_stream_reader.
// The master modport is the reader's view. The slave modport is the
// environment's view: the FIFO and the downstream consumer together.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 64
);
    // FIFO read side
    logic                  rdreq;
    logic [DATA_WIDTH-1:0] q;
    logic                  rdempty;

    // Stream side
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output rdreq,
        input  q,
        input  rdempty,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rdreq,
        output q,
        output rdempty,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for the dual-clock FIFO, running in the rdclk domain.
// It issues rdreq against the FIFO's registered q and absorbs the one-cycle
// read latency in a 3-entry skid buffer. Words are presented on a valid/ready
// stream at one word per cycle.
// Optional packet framing: define FIFO_READER_LAST_EN to drive out_last on
// every PKT_WORDS-th beat. Without it, out_last is tied low.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_WORDS  = 4
) (
    input  logic                 rdclk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 idle,
    fifo_stream_reader_if.master bus
);

    localparam logic [1:0] LAST_IDX = 2'd2;

    // A zero-length packet is meaningless, so reject it at elaboration.
    if (PKT_WORDS < 1) begin : g_bad_pkt_words
        $error("fifo_stream_reader: PKT_WORDS must be at least 1");
    end

    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic [1:0]            count;
    logic                  inflight;
    logic [2:0]            occupancy;
    logic                  pop;

    // Advance a buffer index, wrapping 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

    // Words held in the buffer plus the word currently coming back from the FIFO.
    assign occupancy = {1'b0, count} + {2'b00, inflight};

    // Reads are issued only when the buffer can still absorb the answer.
    // count and inflight are both registers, so out_ready has no
    // combinational path to rdreq. Reset holds rdreq low.
    assign bus.rdreq = rst_n && en && !bus.rdempty && (occupancy < 3'd3);

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = buf_mem[rd_idx];
    assign pop           = bus.out_valid && bus.out_ready;
    assign idle          = (count == 2'd0) && !inflight;

    // Buffer state: capture the returning FIFO word at the tail and pop at the head.
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            wr_idx   <= 2'd0;
            rd_idx   <= 2'd0;
            count    <= 2'd0;
            // NOTE: the buffer is reset (not left as-is) because out_data is
            // read straight from the head entry and must show zero after reset.
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the values from before this clock edge.
            inflight <= bus.rdreq;
            if (inflight) begin
                buf_mem[wr_idx] <= bus.q;
                wr_idx          <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_READER_LAST_EN
    localparam int              BEAT_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_WORDS - 1);

    logic [BEAT_W-1:0] beat;

    // Beat position in the current packet; advances on each pop and wraps after the last beat.
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == BEAT_LAST) ? '0 : beat + BEAT_W'(1);
        end
    end

    assign bus.out_last = bus.out_valid && (beat == BEAT_LAST);
`else
    assign bus.out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader. A small behavioural FIFO with a
// registered q feeds the reader. Each scenario task drives its stimulus and
// compares the observed stream against hand-computed expected values.
module tb_fifo_stream_reader;

    localparam int DW  = 64;
    localparam int PKT = 4;

    logic rdclk = 1'b0;
    logic rst_n;
    logic en;
    logic idle;

    always #5 rdclk = ~rdclk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .PKT_WORDS (PKT)
    ) dut (
        .rdclk(rdclk),
        .rst_n(rst_n),
        .en   (en),
        .idle (idle),
        .bus  (bus.master)
    );

    // Behavioural FIFO: q is registered, and reset flushes it together with the reader.
    logic [DW-1:0] fifo_mem [1024];
    int fifo_head   = 0;
    int fifo_tail   = 0;
    int reads_total = 0;
    int bad_req     = 0;

    assign bus.rdempty = (fifo_head == fifo_tail);

    always @(posedge rdclk) begin
        if (!rst_n) begin
            fifo_head <= fifo_tail;
        end else if (bus.rdreq && !bus.rdempty) begin
            bus.q       <= fifo_mem[fifo_head];
            fifo_head   <= fifo_head + 1;
            reads_total <= reads_total + 1;
        end
    end

    // Count any read request raised against an empty FIFO.
    always @(posedge rdclk) begin
        if (bus.rdreq && bus.rdempty) bad_req <= bad_req + 1;
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] rx_data [256];
    logic          rx_last [256];
    int            deliv_total = 0;
    int            max_osd     = 0;

    task automatic step();
        @(posedge rdclk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[fifo_tail] = w;
        fifo_tail = fifo_tail + 1;
    endtask

    // Collect up to n accepted words within a cycle budget; gaps counts idle cycles after the first word.
    task automatic collect(input int n, input int budget, input bit rand_ready,
                           output int got, output int gaps);
        got  = 0;
        gaps = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (reads_total - deliv_total > max_osd) max_osd = reads_total - deliv_total;
            if (bus.out_valid && bus.out_ready) begin
                rx_data[got] = bus.out_data;
                rx_last[got] = bus.out_last;
                got++;
                deliv_total++;
            end else if (got > 0) begin
                gaps++;
            end
            step();
        end
    endtask

    // Drop en and drain until the reader reports idle (bounded).
    task automatic settle();
        en = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && !idle; c++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        n_checks++; if (bus.rdreq !== 1'b0) $display("FAIL reset_rdreq got=%b exp=0", bus.rdreq); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", bus.out_last); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++; if (idle !== 1'b1) $display("FAIL post_reset_idle got=%b exp=1", idle); else n_pass++;
    endtask

    task automatic test_basic_latency();
        bus.out_ready = 1'b1;
        push(64'h11);
        push(64'h22);
        push(64'h33);
        en = 1'b1;
        #1;
        // cycle 0
        n_checks++; if (bus.rdreq !== 1'b1) $display("FAIL basic_c0_rdreq got=%b exp=1", bus.rdreq); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_c0_valid got=%b exp=0", bus.out_valid); else n_pass++;
        step(); // cycle 1
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_c1_valid got=%b exp=0", bus.out_valid); else n_pass++;
        step(); // cycle 2
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h11)
            $display("FAIL basic_c2_word got=%b/%h exp=1/11", bus.out_valid, bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL basic_c2_last got=%b exp=0", bus.out_last); else n_pass++;
        step(); // cycle 3
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h22)
            $display("FAIL basic_c3_word got=%b/%h exp=1/22", bus.out_valid, bus.out_data); else n_pass++;
        n_checks++; if (bus.rdreq !== 1'b0) $display("FAIL basic_c3_rdreq_empty got=%b exp=0", bus.rdreq); else n_pass++;
        step(); // cycle 4
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h33)
            $display("FAIL basic_c4_word got=%b/%h exp=1/33", bus.out_valid, bus.out_data); else n_pass++;
        step(); // cycle 5
        n_checks++; if (bus.out_valid !== 1'b0 || idle !== 1'b1)
            $display("FAIL basic_c5_idle got valid=%b idle=%b exp valid=0 idle=1", bus.out_valid, idle); else n_pass++;
        settle();
        deliv_total += 3;
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        int got;
        int gaps;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(64'h100 + 64'(i));
        en = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (bus.rdreq) pulses++;
            step();
        end
        n_checks++; if (pulses !== 3) $display("FAIL bp_rdreq_pulses got=%0d exp=3", pulses); else n_pass++;
        n_checks++; if (dut.count !== 2'd3) $display("FAIL bp_count got=%0d exp=3", dut.count); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h100)
            $display("FAIL bp_head got=%b/%h exp=1/100", bus.out_valid, bus.out_data); else n_pass++;
        step();
        step();
        n_checks++; if (bus.out_data !== 64'h100) $display("FAIL bp_head_stable got=%h exp=100", bus.out_data); else n_pass++;
        bus.out_ready = 1'b1;
        collect(10, 40, 1'b0, got, gaps);
        n_checks++; if (got !== 10) $display("FAIL bp_delivered got=%0d exp=10", got); else n_pass++;
        n_checks++; if (gaps !== 0) $display("FAIL bp_gaps got=%0d exp=0", gaps); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (rx_data[i] !== 64'h100 + 64'(i))
                $display("FAIL bp_word%0d got=%h exp=%h", i, rx_data[i], 64'h100 + 64'(i)); else n_pass++;
        end
        settle();
    endtask

    task automatic test_random_stalls();
        logic [DW-1:0] exp_w [200];
        int got;
        int gaps;
        int errs = 0;
        for (int i = 0; i < 200; i++) begin
            exp_w[i] = {$urandom, $urandom};
            push(exp_w[i]);
        end
        max_osd = 0;
        en = 1'b1;
        collect(200, 3000, 1'b1, got, gaps);
        for (int i = 0; i < got; i++) if (rx_data[i] !== exp_w[i]) errs++;
        n_checks++; if (got !== 200) $display("FAIL rand_delivered got=%0d exp=200", got); else n_pass++;
        n_checks++; if (errs !== 0) $display("FAIL rand_order got=%0d wrong words exp=0", errs); else n_pass++;
        n_checks++; if (max_osd > 3) $display("FAIL rand_outstanding got=%0d exp<=3", max_osd); else n_pass++;
        n_checks++; if (bad_req !== 0) $display("FAIL rand_rdreq_on_empty got=%0d exp=0", bad_req); else n_pass++;
        settle();
    endtask

    task automatic test_en_drop();
        int got;
        int gaps;
        int extra = 0;
        bus.out_ready = 1'b1;
        push(64'hA1);
        push(64'hA2);
        push(64'hA3);
        en = 1'b1;
        #1;
        n_checks++; if (bus.rdreq !== 1'b1) $display("FAIL endrop_c0_rdreq got=%b exp=1", bus.rdreq); else n_pass++;
        step();
        en = 1'b0;
        #1;
        n_checks++; if (bus.rdreq !== 1'b0) $display("FAIL endrop_c1_rdreq got=%b exp=0", bus.rdreq); else n_pass++;
        collect(1, 6, 1'b0, got, gaps);
        n_checks++; if (got !== 1 || rx_data[0] !== 64'hA1)
            $display("FAIL endrop_inflight_word got=%0d/%h exp=1/a1", got, rx_data[0]); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (bus.rdreq) extra++;
            step();
        end
        n_checks++; if (extra !== 0 || bus.out_valid !== 1'b0)
            $display("FAIL endrop_quiet got rdreq=%0d valid=%b exp 0/0", extra, bus.out_valid); else n_pass++;
        en = 1'b1;
        #1;
        n_checks++; if (bus.rdreq !== 1'b1) $display("FAIL endrop_resume_rdreq got=%b exp=1", bus.rdreq); else n_pass++;
        collect(2, 10, 1'b0, got, gaps);
        n_checks++; if (got !== 2 || rx_data[0] !== 64'hA2 || rx_data[1] !== 64'hA3)
            $display("FAIL endrop_rest got=%0d %h %h exp=2 a2 a3", got, rx_data[0], rx_data[1]); else n_pass++;
        settle();
    endtask

    task automatic test_reset_mid_stream();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(64'hC0 + 64'(i));
        en = 1'b1;
        step();
        step();
        step();
        n_checks++; if (dut.count !== 2'd2 || dut.inflight !== 1'b1)
            $display("FAIL rstmid_setup got count=%0d inflight=%b exp 2/1", dut.count, dut.inflight); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rdreq !== 1'b0) $display("FAIL rstmid_rdreq got=%b exp=0", bus.rdreq); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL rstmid_data got=%h exp=0", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL rstmid_last got=%b exp=0", bus.out_last); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rstmid_idle got=%b exp=1", idle); else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (idle !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL rstmid_release got idle=%b valid=%b exp 1/0", idle, bus.out_valid); else n_pass++;
        settle();
    endtask

    task automatic test_packet_last();
        int got;
        int gaps;
        int errs = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(64'hD0 + 64'(i));
        en = 1'b1;
        collect(8, 30, 1'b0, got, gaps);
        n_checks++; if (got !== 8) $display("FAIL last_delivered got=%0d exp=8", got); else n_pass++;
`ifdef FIFO_READER_LAST_EN
        for (int i = 0; i < 8; i++) if (rx_last[i] !== ((i == 3) || (i == 7))) errs++;
        n_checks++; if (errs !== 0) $display("FAIL last_beats_4_8 got=%0d wrong beats exp=0", errs); else n_pass++;
        push(64'hE0);
        push(64'hE1);
        collect(2, 10, 1'b0, got, gaps);
        settle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(64'hF0 + 64'(i));
        en = 1'b1;
        collect(4, 20, 1'b0, got, gaps);
        errs = 0;
        for (int i = 0; i < 4; i++) if (rx_last[i] !== (i == 3)) errs++;
        n_checks++; if (got !== 4 || errs !== 0)
            $display("FAIL last_after_reset got=%0d words %0d wrong beats exp=4/0", got, errs); else n_pass++;
`else
        for (int i = 0; i < 8; i++) if (rx_last[i] !== 1'b0) errs++;
        n_checks++; if (errs !== 0) $display("FAIL last_tied_low got=%0d set beats exp=0", errs); else n_pass++;
`endif
        settle();
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_backpressure();
        test_random_stalls();
        test_en_drop();
        test_reset_mid_stream();
        test_packet_last();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit in case the DUT stalls a scenario beyond its bound.
    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=time limit exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the dual-clock `fifo`, running in its `rdclk` domain. It issues `rdreq` against the FIFO's registered `q` and absorbs the one-cycle read latency in a 3-entry skid buffer. It presents the words on a valid/ready stream at full throughput, and can optionally frame the stream into fixed-length packets. It feeds the downstream CXL/RDMA flit consumers.

## Interface
- `DATA_WIDTH`, 64, word width; must match the FIFO's `DATA_WIDTH`.
- `PKT_WORDS`, 4, beats per packet for `out_last` framing; must be ≥1. Used only with `FIFO_READER_LAST_EN`.
- `rdclk` in 1: the single clock, the same clock as the FIFO's `rdclk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: when high, the block may issue new FIFO reads; words already in flight always complete.
- `q` in `DATA_WIDTH`: FIFO read data, valid in the cycle after an accepted `rdreq`.
- `rdempty` in 1: FIFO empty flag.
- `rdreq` out 1: FIFO read request.
- `out_valid` out 1: stream word valid.
- `out_data` out `DATA_WIDTH`: stream word.
- `out_last` out 1: last beat of a packet.
- `out_ready` in 1: downstream accepts the word.
- `idle` out 1: buffer empty and no read in flight.

## Operation
- **State:**
  - 3-entry circular buffer with 2-bit write/read indices and a 2-bit `count` (0..3).
  - `inflight` flag, a register equal to the previous cycle's `rdreq`.
- **Read issue:** `rdreq = en && !rdempty && (count + inflight) < 3`.
  - `count` and `inflight` are registers, so `out_ready` has no combinational path to `rdreq`.
  - `rdreq` is never asserted while `rdempty=1`.
- **Capture:** when `inflight=1`, `q` is written to the buffer tail at the clock edge.
  - The issue rule guarantees the buffer is never full when a word is captured.
  - Capture is never dropped and never stalls.
- **Output:**
  - `out_valid = (count != 0)`.
  - `out_data` is the buffer head.
  - A pop occurs when `out_valid && out_ready`.
- **Simultaneous capture and pop:** `count` is unchanged and both indices advance, wrapping 2→0.
- **Ordering:** words leave in strict FIFO order, with no duplication and no loss.
- **`idle`:** `idle = (count==0) && !inflight`.
- **`en` deasserted mid-stream:** reads stop the same cycle. An in-flight word is still captured and delivered.
- **Reset mid-operation:**
  - Buffer contents and the in-flight word are discarded.
  - The FIFO itself is not reset by this block; the system resets both together.

## Timing
- Reset values: `rdreq=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `idle=1`, `count=0`, `inflight=0`, beat counter 0.
- Latency: `rdreq` in cycle N → `q` valid in cycle N+1 → `out_valid` in cycle N+2.
- Throughput: with the FIFO non-empty and `out_ready` held at 1, one word is delivered per cycle in steady state.
- Backpressure:
  - While `out_valid=1` and `out_ready=0`, `out_data` and `out_last` hold stable.
  - Up to 3 words are buffered; `rdreq` stops once `count + inflight = 3`.
- `rdempty` rises while a read is in flight: that word still arrives; no further `rdreq` is issued.

## Configuration
- `FIFO_READER_LAST_EN` defined:
  - A beat counter (width `$clog2(PKT_WORDS)`, minimum 1 bit) increments on each pop.
  - `out_last = out_valid && (beat == PKT_WORDS-1)`.
  - After the pop of the last beat, the counter wraps to 0.
  - The counter resets to 0, so a packet interrupted by reset restarts at beat 0.
  - If `PKT_WORDS=1`, `out_last` equals `out_valid`.
- Not defined: `out_last` is tied to 0 and the counter logic is not compiled.

## Test plan
- **Basic latency:** reset, then FIFO preloaded with `0x11`, `0x22`, `0x33`, `en=1`, `out_ready=1` → `rdreq` high from cycle 0; `out_valid` first high in cycle 2 with `0x11`; `0x22` and `0x33` follow on consecutive cycles; `idle` returns to 1.
- **Full backpressure:** 10 words queued, `out_ready=0` → exactly 3 `rdreq` pulses; `count=3`; `out_data=word0` held stable. Releasing `out_ready` → all 10 words delivered in order with no gaps after the first.
- **Random stalls:** 200 random words, `out_ready` random at 50% → output sequence identical to the input; never more than 3 words outstanding; `rdreq` never asserted with `rdempty=1`.
- **`en` drop:** deassert `en` in the cycle `rdreq` is high → that word is still delivered; no further `rdreq` until `en` is reasserted.
- **Reset mid-stream:** assert `rst_n=0` with `count=2` and `inflight=1` → all outputs take their reset values immediately; `idle=1` after release.
- **`FIFO_READER_LAST_EN`, `PKT_WORDS=4`:** 8 words → `out_last` on beats 4 and 8 only. A reset after beat 2, then 4 words → `out_last` on the 4th word after reset.
